// File: rtl/dspl_pkg.sv
// Shared types and constants for the display message scheduler.
package dspl_pkg;
  localparam int DIGIT_W    = 6;
  localparam int NUM_DIGITS = 8;
  localparam int ENABLE_BIT = 5;
  localparam logic [DIGIT_W-1:0] BLANK = 6'd0;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;
endpackage

// File: rtl/dspl_tick_gen.sv
// Millisecond tick: pulses once every 2*HALF_MS_COUNT cycles while restart is low.
module dspl_tick_gen #(
  parameter int HALF_MS_COUNT = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam logic [31:0] LAST = 32'(2 * HALF_MS_COUNT - 1);

  logic [31:0] ms_cnt;

  assign tick = !restart && (ms_cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      ms_cnt <= '0;
    else if (restart || ms_cnt == LAST) ms_cnt <= '0;
    else                               ms_cnt <= ms_cnt + 32'd1;
  end
endmodule

// File: rtl/dspl_msg_sched.sv
// Overlays timed messages on the background digits, with a one-entry pending buffer.
// Define DSPL_MSG_BLINK_EN to blink message enable bits every BLINK_MS ms.
module dspl_msg_sched
  import dspl_pkg::*;
#(
  parameter int HALF_MS_COUNT = 50000,
  parameter int HOLD_MS       = 1500,
  parameter int BLINK_MS      = 250
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] game_digits,
  input  logic                          msg_valid,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] msg_digits,
  output logic                          msg_ready,
  input  logic                          clr,
  output logic [DIGIT_W-1:0]            d1,
  output logic [DIGIT_W-1:0]            d2,
  output logic [DIGIT_W-1:0]            d3,
  output logic [DIGIT_W-1:0]            d4,
  output logic [DIGIT_W-1:0]            d5,
  output logic [DIGIT_W-1:0]            d6,
  output logic [DIGIT_W-1:0]            d7,
  output logic [DIGIT_W-1:0]            d8,
  output logic                          busy
);
  if (HALF_MS_COUNT < 1) begin : g_chk_half
    $error("HALF_MS_COUNT must be at least 1");
  end
  if (HOLD_MS < 1 || HOLD_MS > 65535) begin : g_chk_hold
    $error("HOLD_MS out of range 1..65535");
  end
  if (BLINK_MS < 1 || BLINK_MS > 65535) begin : g_chk_blink
    $error("BLINK_MS out of range 1..65535");
  end

  state_t      state, state_nxt;
  logic        reset_done, pend_full, tick, accept, expire;
  logic        busy_nxt;
  digits_t     pend_data, show_data, disp, disp_nxt;
  logic [15:0] hold_cnt;

  assign msg_ready = ~pend_full & ~clr & reset_done;
  assign accept    = msg_valid & msg_ready;
  assign expire    = (state == SHOW) && tick && (hold_cnt == 16'(HOLD_MS - 1));

  dspl_tick_gen #(.HALF_MS_COUNT(HALF_MS_COUNT)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (state != SHOW),
    .tick    (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = SHOW;
      SHOW:    if (expire) state_nxt = (pend_full | accept) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

`ifdef DSPL_MSG_BLINK_EN
  logic [15:0] blink_cnt;
  logic        blink_phase, phase_nxt, blink_wrap;

  assign blink_wrap = (blink_cnt == 16'(BLINK_MS - 1));

  always_comb begin
    phase_nxt = blink_phase;
    if (state == LOAD)                            phase_nxt = 1'b1;
    else if (state == SHOW && tick && blink_wrap) phase_nxt = ~blink_phase;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_phase <= phase_nxt;
      if (state == LOAD)                 blink_cnt <= '0;
      else if (state == SHOW && tick)    blink_cnt <= blink_wrap ? 16'd0 : blink_cnt + 16'd1;
    end
  end
`endif

  // LOAD from SHOW holds the previous message so back-to-back messages do not flash the background.
  always_comb begin
    disp_nxt = disp;
    busy_nxt = busy;
    if (state_nxt == SHOW) begin
      disp_nxt = (state == LOAD) ? pend_data : show_data;
`ifdef DSPL_MSG_BLINK_EN
      for (int k = 0; k < NUM_DIGITS; k++)
        disp_nxt[k][ENABLE_BIT] = disp_nxt[k][ENABLE_BIT] & phase_nxt;
`endif
      busy_nxt = 1'b1;
    end else if (state == IDLE || state_nxt == IDLE) begin
      disp_nxt = game_digits;
      busy_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      reset_done <= 1'b0;
      pend_full  <= 1'b0;
      pend_data  <= '0;
      show_data  <= '0;
      hold_cnt   <= '0;
      disp       <= {NUM_DIGITS{BLANK}};
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      reset_done <= 1'b1;
      disp       <= disp_nxt;
      busy       <= busy_nxt;
      if (clr) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
        pend_data <= msg_digits;
      end else if (state == LOAD) begin
        pend_full <= 1'b0;
      end
      if (state == LOAD) begin
        show_data <= pend_data;
        hold_cnt  <= '0;
      end else if (state == SHOW && tick) begin
        hold_cnt  <= hold_cnt + 16'd1;
      end
    end
  end

  assign d1 = disp[0];
  assign d2 = disp[1];
  assign d3 = disp[2];
  assign d4 = disp[3];
  assign d5 = disp[4];
  assign d6 = disp[5];
  assign d7 = disp[6];
  assign d8 = disp[7];
endmodule

// File: tb/tb_dspl_msg_sched.sv
// Scoreboard bench for dspl_msg_sched: 1 ms = 4 cycles, 3 ms hold, 1 ms blink.
module tb_dspl_msg_sched;
  localparam logic [47:0] G  = 48'h820820820820;
  localparam logic [47:0] G2 = 48'h9E71C50A3F61;
  localparam logic [47:0] M  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] A  = {6'h28, 6'h27, 6'h26, 6'h25, 6'h24, 6'h23, 6'h22, 6'h21};
  localparam logic [47:0] B  = {6'h38, 6'h37, 6'h36, 6'h35, 6'h34, 6'h33, 6'h32, 6'h31};
`ifdef DSPL_MSG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, msg_valid, clr, msg_ready, busy;
  logic [47:0] game_digits, msg_digits, dv;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

  dspl_msg_sched #(.HALF_MS_COUNT(2), .HOLD_MS(3), .BLINK_MS(1)) dut (
    .clock(clock), .reset_n(reset_n), .game_digits(game_digits),
    .msg_valid(msg_valid), .msg_digits(msg_digits), .msg_ready(msg_ready),
    .clr(clr), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .d7(d7), .d8(d8), .busy(busy)
  );

  always #5 clock = ~clock;
  assign dv = {d8, d7, d6, d5, d4, d3, d2, d1};

  typedef struct {
    int          cyc;
    logic [47:0] d;
    logic        busy;
    logic        rdy;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   drain_to = 1'b0;

  // Expected enable bits cleared when the blink phase is off.
  function automatic logic [47:0] blk(input logic [47:0] v, input bit ph);
    logic [47:0] r;
    r = v;
    if (BLINK && !ph)
      for (int k = 0; k < 8; k++) r[6*k+5] = 1'b0;
    return r;
  endfunction

  task automatic exp_rel(input int k, input logic [47:0] d, input logic b,
                         input logic r, input string nm);
    q.push_back('{cyc + k, d, b, r, nm});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: due at cycle %0d, reached at cycle %0d", e.nm, e.cyc, cyc);
      end else if (dv !== e.d || busy !== e.busy || msg_ready !== e.rdy) begin
        bad++;
        $display("FAIL %s: got d=%h busy=%b rdy=%b, want d=%h busy=%b rdy=%b",
                 e.nm, dv, busy, msg_ready, e.d, e.busy, e.rdy);
      end
    end
    if (drain_to && q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks never reached, want 0", q.size());
      q.delete();
    end
  end

  initial begin
    reset_n = 1'b0; clr = 1'b0; msg_valid = 1'b0; msg_digits = '0; game_digits = G;

    // reset and release
    exp_rel(1, 48'd0, 1'b0, 1'b0, "rst_hold");
    step(2);
    reset_n = 1'b1;
    exp_rel(0, 48'd0, 1'b0, 1'b0, "rel_no_edge");
    exp_rel(1, G, 1'b0, 1'b1, "rel_first_edge");
    step(2);

    // background follows game_digits with one cycle of latency
    game_digits = G2;
    exp_rel(0, G, 1'b0, 1'b1, "idle_old");
    exp_rel(1, G2, 1'b0, 1'b1, "idle_lat");
    step(1);
    game_digits = G;
    step(1);

    // single message: LOAD, then 12 SHOW cycles
    exp_rel(1, G, 1'b0, 1'b0, "m1_load");
    exp_rel(2, M, 1'b1, 1'b1, "m1_first");
    exp_rel(6, blk(M, 1'b0), 1'b1, 1'b1, "m1_win2");
    exp_rel(10, M, 1'b1, 1'b1, "m1_win3");
    exp_rel(13, M, 1'b1, 1'b1, "m1_last");
    exp_rel(14, G, 1'b0, 1'b1, "m1_done");
    msg_valid = 1'b1; msg_digits = M;
    step(1);
    msg_valid = 1'b0;
    step(14);

    // second message queued mid-SHOW runs after one LOAD cycle
    exp_rel(1, G, 1'b0, 1'b0, "m2_load");
    exp_rel(2, A, 1'b1, 1'b1, "a_first");
    exp_rel(5, A, 1'b1, 1'b0, "pend_rdy");
    exp_rel(13, A, 1'b1, 1'b0, "a_last");
    exp_rel(14, A, 1'b1, 1'b0, "load_hold");
    exp_rel(15, B, 1'b1, 1'b1, "b_first");
    exp_rel(19, blk(B, 1'b0), 1'b1, 1'b1, "b_win2");
    exp_rel(26, B, 1'b1, 1'b1, "b_last");
    exp_rel(27, G, 1'b0, 1'b1, "b_done");
    msg_valid = 1'b1; msg_digits = A;
    step(1);
    msg_valid = 1'b0;
    step(3);
    msg_valid = 1'b1; msg_digits = B;
    step(1);
    msg_valid = 1'b0;
    step(23);

    // clr with msg_valid while SHOW with pending full
    exp_rel(2, A, 1'b1, 1'b1, "c_show");
    exp_rel(6, blk(A, 1'b0), 1'b1, 1'b0, "clr_cyc");
    exp_rel(7, G, 1'b0, 1'b1, "clr_idle");
    exp_rel(9, G, 1'b0, 1'b1, "clr_noacc");
    exp_rel(16, G, 1'b0, 1'b1, "clr_stay");
    msg_valid = 1'b1; msg_digits = A;
    step(1);
    msg_valid = 1'b0;
    step(3);
    msg_valid = 1'b1; msg_digits = B;
    step(1);
    msg_valid = 1'b0;
    step(1);
    clr = 1'b1; msg_valid = 1'b1; msg_digits = M;
    step(1);
    clr = 1'b0; msg_valid = 1'b0;
    step(16);

    // asynchronous reset mid-SHOW, sampled before any further edge
    exp_rel(2, A, 1'b1, 1'b1, "r_show");
    exp_rel(5, 48'd0, 1'b0, 1'b0, "async_rst");
    exp_rel(7, G, 1'b0, 1'b1, "r_back");
    msg_valid = 1'b1; msg_digits = A;
    step(1);
    msg_valid = 1'b0;
    step(4);
    #1 reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(3);

    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clock);
    drain_to = 1'b1;
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
